ysyx_23060208_lsu_axi: RTL and testbench

//  Initiator (master) side of the LSU data-memory bus; drives the 5-channel AW/W/B/AR/R handshake into the dsram.

---
 rtl/ysyx_23060208_pkg.sv | 10 +
 rtl/ysyx_23060208_load_ext.sv | 27 ++
 rtl/ysyx_23060208_lsu_axi.sv | 118 +++++++++++
 tb/tb_ysyx_23060208_lsu_axi.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060208_pkg.sv
// ysyx_23060208_pkg: shared LSU bus FSM states, load funct3 codes and AXI response codes
package ysyx_23060208_pkg;
    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B, RESP} lsu_state_t;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/ysyx_23060208_load_ext.sv
// ysyx_23060208_load_ext: selects the load lane from a bus word and sign/zero-extends it
//   data    in  bus word as returned by the slave
//   addr_lo in  low address bits picking the byte/half lane
//   funct3  in  load type (lb/lh/lw/lbu/lhu, anything else returns the whole word)
//   ext     out extended load result
module ysyx_23060208_load_ext
    import ysyx_23060208_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b   = data[{addr_lo, 3'b000} +: 8];
        h   = data[{addr_lo[1], 4'b0000} +: 16];
        ext = funct3 == F3_LB  ? {{(DATA_WIDTH-8){b[7]}}, b} :
              funct3 == F3_LH  ? {{(DATA_WIDTH-16){h[15]}}, h} :
              funct3 == F3_LBU ? {{(DATA_WIDTH-8){1'b0}}, b} :
              funct3 == F3_LHU ? {{(DATA_WIDTH-16){1'b0}}, h} :
              funct3 == F3_LW  ? data : data;
    end
endmodule

// File: rtl/ysyx_23060208_lsu_axi.sv
// ysyx_23060208_lsu_axi: LSU bus initiator running one AXI-style load or store per EXU request
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           EXU request handshake (ready only while idle)
//   req_wen/addr/wdata/wstrb/funct3  request payload, latched on acceptance
//   resp_valid/resp_rdata/resp_err   one-cycle completion pulse with extended load data
//   dsram_aw*/w*/b*/ar*/r*        five-channel bus to the dsram slave
module ysyx_23060208_lsu_axi
    import ysyx_23060208_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_wstrb,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] dsram_awaddr,
    output logic                  dsram_awvalid,
    input  logic                  dsram_awready,
    output logic [DATA_WIDTH-1:0] dsram_wdata,
    output logic [2:0]            dsram_wstrb,
    output logic                  dsram_wvalid,
    input  logic                  dsram_wready,
    input  logic [1:0]            dsram_bresp,
    input  logic                  dsram_bvalid,
    output logic                  dsram_bready,
    output logic [ADDR_WIDTH-1:0] dsram_araddr,
    output logic                  dsram_arvalid,
    input  logic                  dsram_arready,
    input  logic [DATA_WIDTH-1:0] dsram_rdata,
    input  logic [1:0]            dsram_rresp,
    input  logic                  dsram_rvalid,
    output logic                  dsram_rready
);
    lsu_state_t            state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q, ext_data;
    logic [2:0]            wstrb_q, funct3_q;
    logic [1:0]            resp_q;
    logic                  wen_q, aw_done, w_done;

    ysyx_23060208_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
        .data    (rdata_q),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .ext     (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            funct3_q <= '0;
            wen_q    <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rdata_q  <= '0;
            resp_q   <= RESP_OKAY;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                wstrb_q  <= req_wstrb;
                funct3_q <= req_funct3;
                wen_q    <= req_wen;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end
            // AW and W complete independently; each valid drops once its own flag is set
            if (state == WR_AWW) begin
                aw_done <= aw_done | dsram_awready;
                w_done  <= w_done | dsram_wready;
            end
            if (dsram_rvalid && dsram_rready) begin
                rdata_q <= dsram_rdata;
                resp_q  <= dsram_rresp;
            end
            if (dsram_bvalid && dsram_bready) resp_q <= dsram_bresp;
        end
    end

    always_comb begin
        state_n       = state;
        req_ready     = state == IDLE && !rst;
        dsram_araddr  = addr_q;
        dsram_awaddr  = addr_q;
        dsram_wdata   = wdata_q;
        dsram_wstrb   = wstrb_q;
        dsram_arvalid = state == RD_AR;
        dsram_rready  = state == RD_R;
        dsram_awvalid = state == WR_AWW && !aw_done;
        dsram_wvalid  = state == WR_AWW && !w_done;
        dsram_bready  = state == WR_B;
        resp_valid    = state == RESP;
        resp_err      = state == RESP && resp_q != RESP_OKAY;
        resp_rdata    = (state == RESP && !wen_q) ? ext_data : '0;
        case (state)
            IDLE:    state_n = req_valid ? (req_wen ? WR_AWW : RD_AR) : IDLE;
            RD_AR:   state_n = dsram_arready ? RD_R : RD_AR;
            RD_R:    state_n = dsram_rvalid ? RESP : RD_R;
            WR_AWW:  state_n = ((aw_done || dsram_awready) && (w_done || dsram_wready)) ? WR_B : WR_AWW;
            WR_B:    state_n = dsram_bvalid ? RESP : WR_B;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ysyx_23060208_lsu_axi.sv
// tb_ysyx_23060208_lsu_axi: directed bench with a reactive dsram slave and a transaction-level response model
module tb_ysyx_23060208_lsu_axi;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_wstrb = '0, req_funct3 = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    ysyx_23060208_lsu_axi dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dsram_awaddr(awaddr), .dsram_awvalid(awvalid), .dsram_awready(awready),
        .dsram_wdata(wdata), .dsram_wstrb(wstrb), .dsram_wvalid(wvalid), .dsram_wready(wready),
        .dsram_bresp(bresp), .dsram_bvalid(bvalid), .dsram_bready(bready),
        .dsram_araddr(araddr), .dsram_arvalid(arvalid), .dsram_arready(arready),
        .dsram_rdata(rdata), .dsram_rresp(rresp), .dsram_rvalid(rvalid), .dsram_rready(rready)
    );

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic [2:0]  wstrb;
        logic        wen, err;
    } exp_t;

    exp_t        exp_q[$];
    int          compared = 0, mismatched = 0;
    int          resp_cnt = 0, ar_cyc = 0, aw_cyc = 0, w_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // load result from the memory word, the byte address and the load type
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * addr[1:0])) & 32'h0000_00FF;
        h = (word >> (16 * addr[1])) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    // reactive slave: ready/valid decided on the falling edge, taken by the DUT on the next rising edge
    initial begin
        int ar_w = 0, r_w = 0, aw_w = 0, w_w = 0, b_w = 0;
        bit r_p = 0, b_p = 0, aw_g = 0, w_g = 0;
        forever begin
            @(negedge clk);
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            if (rst) begin
                ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
                r_p = 0; b_p = 0; aw_g = 0; w_g = 0;
            end else begin
                if (b_p) begin
                    if (b_w >= b_delay) begin bvalid = 1; bresp = s_bresp; b_p = 0; b_w = 0; end
                    else b_w++;
                end
                if (r_p) begin
                    if (r_w >= r_delay) begin rvalid = 1; rdata = s_rdata; rresp = s_rresp; r_p = 0; r_w = 0; end
                    else r_w++;
                end
                if (arvalid) begin
                    if (ar_w >= ar_delay) begin arready = 1; r_p = 1; ar_w = 0; end
                    else ar_w++;
                end
                if (awvalid) begin
                    if (aw_w >= aw_delay) begin awready = 1; aw_g = 1; aw_w = 0; end
                    else aw_w++;
                end
                if (wvalid) begin
                    if (w_w >= w_delay) begin wready = 1; w_g = 1; w_w = 0; end
                    else w_w++;
                end
                if (aw_g && w_g) begin b_p = 1; aw_g = 0; w_g = 0; end
            end
        end
    end

    // compare process: checks outputs against the model every cycle
    initial begin
        logic p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
        logic [31:0] p_ara = 0, p_awa = 0, p_wd = 0;
        logic [2:0] p_ws = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_q.delete();
                chk("rst_ctrl", {23'd0, arvalid, awvalid, wvalid, bready, rready, resp_valid, resp_err, req_ready}, 32'd0);
                chk("rst_rdata", resp_rdata, 32'd0);
            end else begin
                chk("req_ready", req_ready, exp_q.size() == 0);
                if (p_arv && !p_arr) begin chk("ar_hold", arvalid, 1); chk("araddr_hold", araddr, p_ara); end
                if (p_awv && !p_awr) begin chk("aw_hold", awvalid, 1); chk("awaddr_hold", awaddr, p_awa); end
                if (p_wv && !p_wr) begin chk("w_hold", wvalid, 1); chk("wdata_hold", wdata, p_wd); chk("wstrb_hold", wstrb, p_ws); end
                if (exp_q.size() > 0) begin
                    if (arvalid) chk("araddr", araddr, exp_q[0].addr);
                    if (awvalid) chk("awaddr", awaddr, exp_q[0].addr);
                    if (wvalid) begin chk("wdata", wdata, exp_q[0].wdata); chk("wstrb", wstrb, exp_q[0].wstrb); end
                    if (arvalid || rready) chk("rd_on_store", exp_q[0].wen, 0);
                    if (awvalid || wvalid || bready) chk("wr_on_load", exp_q[0].wen, 1);
                end
                ar_cyc += arvalid;
                aw_cyc += awvalid;
                w_cyc += wvalid;
                if (resp_valid) begin
                    resp_cnt++;
                    last_rdata = resp_rdata;
                    last_err = resp_err;
                    if (exp_q.size() == 0) chk("resp_unexpected", resp_valid, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", resp_err, e.err);
                    end
                end
            end
            p_arv = arvalid; p_arr = arready; p_ara = araddr;
            p_awv = awvalid; p_awr = awready; p_awa = awaddr;
            p_wv = wvalid; p_wr = wready; p_wd = wdata; p_ws = wstrb;
        end
    end

    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] ws, input logic [2:0] f3);
        exp_t e;
        int n;
        e.addr = addr; e.wen = wen; e.wdata = wd; e.wstrb = ws;
        e.rdata = wen ? 32'd0 : model_load(f3, addr, s_rdata);
        e.err = (wen ? s_bresp : s_rresp) != 2'b00;
        @(negedge clk);
        req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = ws; req_funct3 = f3;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 0;
            return;
        end
        @(negedge clk);
        req_valid = 0;
        ar_cyc = 0; aw_cyc = 0; w_cyc = 0;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
        chk("resp_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
        int r0 = resp_cnt;
        do_req(0, addr, 32'd0, 3'd0, f3);
        wait_done();
        chk(name, last_rdata, exp);
        chk({name, "_pulse"}, resp_cnt - r0, 1);
    endtask

    initial begin
        int r0, n;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);

        s_rdata = 32'hDEAD_BEEF;
        load_chk("t1_lw", 3'b010, 32'h8000_0004, 32'hDEAD_BEEF);
        chk("t1_err", last_err, 0);

        s_rdata = 32'h80FF_0000;
        load_chk("t2_lb", 3'b000, 32'h8000_0003, 32'hFFFF_FF80);
        load_chk("t2_lbu", 3'b100, 32'h8000_0003, 32'h0000_0080);
        load_chk("t2_lh", 3'b001, 32'h8000_0002, 32'hFFFF_80FF);
        load_chk("t2_lhu", 3'b101, 32'h8000_0002, 32'h0000_80FF);
        load_chk("t2_lbu0", 3'b100, 32'h8000_0000, 32'h0000_0000);
        load_chk("t2_bad_f3", 3'b011, 32'h8000_0001, 32'h80FF_0000);

        aw_delay = 3;
        r0 = resp_cnt;
        do_req(1, 32'h8000_0010, 32'h1234_5678, 3'b010, 3'b000);
        wait_done();
        aw_delay = 0;
        chk("t3_aw_cycles", aw_cyc, 4);
        chk("t3_w_cycles", w_cyc, 1);
        chk("t3_pulse", resp_cnt - r0, 1);
        chk("t3_rdata", last_rdata, 0);
        chk("t3_err", last_err, 0);

        s_bresp = 2'b10;
        do_req(1, 32'h8000_0014, 32'hA5A5_A5A5, 3'b001, 3'b000);
        wait_done();
        s_bresp = 2'b00;
        chk("t4_berr", last_err, 1);
        s_rresp = 2'b10;
        s_rdata = 32'h0000_0042;
        load_chk("t4_rerr_data", 3'b010, 32'h8000_0018, 32'h0000_0042);
        chk("t4_rerr", last_err, 1);
        s_rresp = 2'b00;
        load_chk("t4_clean", 3'b010, 32'h8000_001C, 32'h0000_0042);
        chk("t4_clean_err", last_err, 0);

        ar_delay = 5;
        s_rdata = 32'hCAFE_F00D;
        load_chk("t5_lw", 3'b010, 32'h8000_0008, 32'hCAFE_F00D);
        ar_delay = 0;
        chk("t5_ar_cycles", ar_cyc, 6);

        r_delay = 4;
        s_rdata = 32'h1111_1111;
        do_req(0, 32'h8000_0020, 32'd0, 3'd0, 3'b010);
        n = 0;
        while (!rready && n < 20) begin @(negedge clk); n++; end
        chk("t6_reach_rd_r", rready, 1);
        #1 rst = 1;
        r0 = resp_cnt;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        repeat (8) @(negedge clk);
        chk("t6_no_resp", resp_cnt - r0, 0);
        r_delay = 0;
        s_rdata = 32'h0BAD_CAFE;
        load_chk("t6_after_rst", 3'b010, 32'h8000_0024, 32'h0BAD_CAFE);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
endmodule
